// File: rtl/alk_mdseq_if.sv
// Start/control request and ALPCTL code bus between the issuing logic and the
// ALK multiply/divide sequencer.
interface alk_mdseq_if #(parameter int CNT_W = 6);
   logic             start_h;
   logic [1:0]       op_h;
   logic [CNT_W-1:0] cnt_h;
   logic             fast_en_h;
   logic             sel_n_h;
   logic             abort_h;
   logic [9:0]       alpctl_h;
   logic             loop_flag_h;
   logic             busy_h;
   logic             done_h;

   modport master (
      output start_h, op_h, cnt_h, fast_en_h, sel_n_h, abort_h,
      input  alpctl_h, loop_flag_h, busy_h, done_h
   );

   modport slave (
      input  start_h, op_h, cnt_h, fast_en_h, sel_n_h, abort_h,
      output alpctl_h, loop_flag_h, busy_h, done_h
   );
endinterface

// File: rtl/alk_mdseq.sv
// Multiply/divide micro-step sequencer: emits registered ALPCTL codes and the
// loop flag for MUL, DIV and DIVD loops plus the closing REM cycle.
module alk_mdseq #(
   parameter int CNT_W = 6
) (
   input  logic        clk,
   input  logic        reset_l,
   alk_mdseq_if.slave  bus
);
   typedef enum logic [2:0] {S_IDLE, S_DBL, S_LOOP, S_REM, S_DONE} state_t;

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_DIVD = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] r_q, r_d;
   logic [1:0]       op_q, op_d;
   logic             fast_q, fast_d;
   logic [9:0]       alpctl_q, alpctl_d;
   logic             flag_q, flag_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept;
   logic             use_fast;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q  <= S_IDLE;
         r_q      <= '0;
         op_q     <= OP_MUL;
         fast_q   <= 1'b0;
         alpctl_q <= 10'h000;
         flag_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         op_q     <= op_d;
         fast_q   <= fast_d;
         alpctl_q <= alpctl_d;
         flag_q   <= flag_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign accept = bus.start_h && (state_q == S_IDLE || state_q == S_DONE) &&
                   (bus.op_h != OP_RSVD);

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      op_d    = op_q;
      fast_d  = fast_q;
      if (bus.abort_h) begin
         state_d = S_IDLE;
         r_d     = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               state_d = S_IDLE;
               if (accept) begin
                  op_d   = bus.op_h;
                  fast_d = bus.fast_en_h;
                  r_d    = bus.cnt_h;
                  if (bus.op_h == OP_DIVD)      state_d = S_DBL;
                  else if (bus.cnt_h != '0)     state_d = S_LOOP;
                  else if (bus.op_h == OP_MUL)  state_d = S_DONE;
                  else                          state_d = S_REM;
               end
            end
            S_DBL:  state_d = (r_q != '0) ? S_LOOP : S_REM;
            S_LOOP: begin
               // Count stops at r = 1, so a full-scale N never wraps.
               if (r_q <= CNT_W'(1))
                  state_d = (op_q == OP_MUL) ? S_DONE : S_REM;
               else
                  r_d = r_q - CNT_W'(1);
            end
            S_REM:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are a function of the state being entered and the live sel_n_h,
   // so each code reflects sel sampled at the edge that starts its cycle.
   assign use_fast = fast_d && (r_d > CNT_W'(1));

   always_comb begin
      alpctl_d = 10'h000;
      flag_d   = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_d)
         S_DBL: begin
            busy_d   = 1'b1;
            alpctl_d = bus.sel_n_h ? 10'h27F : 10'h26F;
         end
         S_LOOP: begin
            busy_d = 1'b1;
            flag_d = (r_d > CNT_W'(1));
            if (op_d == OP_MUL) alpctl_d = use_fast ? 10'h269 : 10'h26B;
            else                alpctl_d = use_fast ? 10'h26C : 10'h26E;
            alpctl_d[4] = bus.sel_n_h;
         end
         S_REM: begin
            busy_d   = 1'b1;
            alpctl_d = 10'h26A;
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   assign bus.alpctl_h    = alpctl_q;
   assign bus.loop_flag_h = flag_q;
   assign bus.busy_h      = busy_q;
   assign bus.done_h      = done_q;
endmodule

// File: tb/tb_alk_mdseq.sv
// Directed table-driven bench for alk_mdseq plus hand sequences for abort,
// back-to-back, start-while-busy, full-scale count and async reset.
module tb_alk_mdseq;
   logic clk = 1'b0;
   logic reset_l = 1'b0;
   always #5 clk = ~clk;

   alk_mdseq_if #(.CNT_W(6)) bus ();
   alk_mdseq #(.CNT_W(6)) dut (.clk(clk), .reset_l(reset_l), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [1:0]  op;
      logic [5:0]  n;
      logic        fast;
      logic [7:0]  sel;
      int          len;
      logic [12:0] exp [8];
   } vec_t;

   vec_t tbl [9];

   function automatic logic [12:0] ex(input logic [9:0] c, input logic f, b, d);
      return {c, f, b, d};
   endfunction

   task automatic check(input string name, input logic [12:0] want);
      logic [12:0] got;
      got = {bus.alpctl_h, bus.loop_flag_h, bus.busy_h, bus.done_h};
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got alpctl=%h flag=%b busy=%b done=%b, want alpctl=%h flag=%b busy=%b done=%b",
                  name, got[12:3], got[2], got[1], got[0],
                  want[12:3], want[2], want[1], want[0]);
      end
   endtask

   task automatic start(input logic [1:0] op, input logic [5:0] n,
                        input logic fast, input logic sel);
      bus.start_h = 1'b1; bus.op_h = op; bus.cnt_h = n;
      bus.fast_en_h = fast; bus.sel_n_h = sel;
   endtask

   task automatic step;
      @(posedge clk); @(negedge clk);
   endtask

   localparam logic [12:0] ID = 13'h0;
   localparam logic [12:0] DN = 13'h1;

   initial begin
      logic [12:0] dn_pat;
      int done_cyc, flags, fasts;
      bus.start_h = 0; bus.op_h = 0; bus.cnt_h = 0;
      bus.fast_en_h = 0; bus.sel_n_h = 0; bus.abort_h = 0;
      dn_pat = DN;

      tbl[0] = '{2'b00, 6'd3, 1'b1, 8'b010, 5, '{ex(10'h269,1,1,0), ex(10'h279,1,1,0), ex(10'h26B,0,1,0), DN, ID, ID, ID, ID}};
      tbl[1] = '{2'b01, 6'd2, 1'b0, 8'b001, 5, '{ex(10'h27E,1,1,0), ex(10'h26E,0,1,0), ex(10'h26A,0,1,0), DN, ID, ID, ID, ID}};
      tbl[2] = '{2'b10, 6'd1, 1'b1, 8'b001, 5, '{ex(10'h27F,0,1,0), ex(10'h26E,0,1,0), ex(10'h26A,0,1,0), DN, ID, ID, ID, ID}};
      tbl[3] = '{2'b00, 6'd0, 1'b1, 8'b000, 2, '{DN, ID, ID, ID, ID, ID, ID, ID}};
      tbl[4] = '{2'b01, 6'd0, 1'b1, 8'b000, 3, '{ex(10'h26A,0,1,0), DN, ID, ID, ID, ID, ID, ID}};
      tbl[5] = '{2'b10, 6'd0, 1'b0, 8'b000, 4, '{ex(10'h26F,0,1,0), ex(10'h26A,0,1,0), DN, ID, ID, ID, ID, ID}};
      tbl[6] = '{2'b11, 6'd3, 1'b1, 8'b000, 3, '{ID, ID, ID, ID, ID, ID, ID, ID}};
      tbl[7] = '{2'b01, 6'd3, 1'b1, 8'b000, 6, '{ex(10'h26C,1,1,0), ex(10'h26C,1,1,0), ex(10'h26E,0,1,0), ex(10'h26A,0,1,0), DN, ID, ID, ID}};
      tbl[8] = '{2'b10, 6'd2, 1'b1, 8'b110, 6, '{ex(10'h26F,0,1,0), ex(10'h27C,1,1,0), ex(10'h27E,0,1,0), ex(10'h26A,0,1,0), DN, ID, ID, ID}};

      step; step;
      check("reset_state", ID);
      reset_l = 1'b1;
      step;

      foreach (tbl[i]) begin
         start(tbl[i].op, tbl[i].n, tbl[i].fast, tbl[i].sel[0]);
         for (int k = 1; k <= tbl[i].len; k++) begin
            step;
            bus.start_h = 1'b0;
            check($sformatf("vec%0d_cyc%0d", i, k), tbl[i].exp[k-1]);
            bus.sel_n_h = tbl[i].sel[k];
         end
      end

      // Abort mid-MUL: sampled at E2, idle from cycle 3, never a done pulse.
      start(2'b00, 6'd5, 1'b1, 1'b0);
      step; bus.start_h = 0; check("abort_c1", ex(10'h269,1,1,0));
      step; check("abort_c2", ex(10'h269,1,1,0)); bus.abort_h = 1;
      step; bus.abort_h = 0; check("abort_c3", ID);
      for (int k = 4; k <= 8; k++) begin
         step; check($sformatf("abort_c%0d", k), ID);
      end

      // Abort together with start: start dropped.
      start(2'b01, 6'd2, 1'b0, 1'b0); bus.abort_h = 1;
      step; bus.start_h = 0; bus.abort_h = 0; check("abort_start", ID);

      // Start while busy is ignored.
      start(2'b01, 6'd2, 1'b0, 1'b0);
      step; check("busy_c1", ex(10'h26E,1,1,0)); start(2'b00, 6'd0, 1'b0, 1'b0);
      step; bus.start_h = 0; check("busy_c2", ex(10'h26E,0,1,0));
      step; check("busy_c3", ex(10'h26A,0,1,0));
      step; check("busy_c4", DN);
      step;

      // Start accepted in DONE: next code with no NOP gap.
      start(2'b00, 6'd1, 1'b0, 1'b0);
      step; bus.start_h = 0; check("b2b_c1", ex(10'h26B,0,1,0));
      step; check("b2b_c2", DN); start(2'b00, 6'd2, 1'b1, 1'b1);
      step; bus.start_h = 0; check("b2b_c3", ex(10'h279,1,1,0));
      step; check("b2b_c4", ex(10'h27B,0,1,0));
      step; check("b2b_c5", DN);
      step; check("b2b_c6", ID);

      // Full-scale count: 63 loop cycles, no wrap.
      start(2'b00, 6'd63, 1'b1, 1'b0);
      done_cyc = 0; flags = 0; fasts = 0;
      for (int k = 1; k <= 80; k++) begin
         step; bus.start_h = 0;
         if (bus.loop_flag_h) flags++;
         if (bus.alpctl_h == 10'h269) fasts++;
         if (k == 63) check("max_last_code", ex(10'h26B,0,1,0));
         if (bus.done_h && done_cyc == 0) done_cyc = k;
      end
      n_cmp++;
      if (done_cyc != 64) begin n_bad++; $display("FAIL max_done_cycle: got %0d want 64", done_cyc); end
      n_cmp++;
      if (flags != 62) begin n_bad++; $display("FAIL max_flag_count: got %0d want 62", flags); end
      n_cmp++;
      if (fasts != 62) begin n_bad++; $display("FAIL max_fast_count: got %0d want 62", fasts); end

      // Async reset mid-DIV clears outputs without a clock edge.
      start(2'b01, 6'd4, 1'b0, 1'b0);
      step; bus.start_h = 0; check("rst_pre", ex(10'h26E,1,1,0));
      #2 reset_l = 1'b0;
      #1 check("rst_async", ID);
      @(negedge clk); reset_l = 1'b1;
      step; check("rst_idle1", ID);
      step; check("rst_idle2", ID);
      if (dn_pat !== DN) n_bad++;

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alk_mdseq.md
# alk_mdseq

Multiply/divide micro-step sequencer for the ALK slice of the DPM. It sits on the issuing side of the ALPCTL field. On a single start request it emits the per-cycle ALPCTL codes and the loop flag for MUL, DIV and DIVD (double-length divide) loops, plus the closing REM cycle. Its output feeds the ALK control decode directly, which turns those codes into mul/div/rem/fast-loop and shift-direction strobes.

## Interface
- `CNT_W`, default 6: width of the loop iteration count.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset_l`, in, 1: asynchronous, active-low reset.
- `start_h`, in, 1: request pulse; accepted only in IDLE or DONE.
- `op_h`, in, 2: sampled with start. 00 = MUL, 01 = DIV, 10 = DIVD; 11 is reserved and the start is ignored.
- `cnt_h`, in, CNT_W: number of loop cycles N, sampled with start. N = 0 is legal.
- `fast_en_h`, in, 1: sampled with start; permits FAST loop codes.
- `sel_n_h`, in, 1: datapath sign/recode select, sampled every edge. 1 selects the N (subtract) variant; 0 selects the P variant.
- `abort_h`, in, 1: synchronous abort; highest priority below reset.
- `alpctl_h`, out, 10: registered ALPCTL code.
- `loop_flag_h`, out, 1: registered; high on non-final loop cycles.
- `busy_h`, out, 1: high while codes are being emitted.
- `done_h`, out, 1: one-cycle completion pulse.

## Operation
- Code set, `alpctl_h` (bit 4 = N/P, bit 1 = SLOW/FAST):
  - NOP: 0x000
  - MUL_FAST P/N: 0x269/0x279
  - MUL_SLOW P/N: 0x26B/0x27B
  - DIV_FAST P/N: 0x26C/0x27C
  - DIV_SLOW P/N: 0x26E/0x27E
  - REM: 0x26A
  - DIVD A/S: 0x26F/0x27F
- States: IDLE, DBL, LOOP, REM, DONE.
- Accepted start:
  - Latches op, fast_en, and remaining count r = N.
  - Next state: DIVD → DBL; DIV/MUL with N > 0 → LOOP; DIV with N = 0 → REM; MUL with N = 0 → DONE.
- DBL (one cycle):
  - Emits DIVD_A if sel_n_h = 0, DIVD_S if sel_n_h = 1.
  - Next state: LOOP if N > 0, else REM.
- LOOP (one cycle per r, counting r down from N to 1):
  - Emits the MUL or DIV code.
  - FAST iff latched fast_en = 1 and r ≥ 2; otherwise SLOW.
  - N/P variant follows sel_n_h.
  - loop_flag_h = 1 iff r ≥ 2.
  - At r = 1: MUL → DONE, DIV/DIVD → REM.
- REM (one cycle): emits REM, then DONE.
- DONE (one cycle):
  - alpctl_h = NOP, done_h = 1.
  - A start in this cycle is accepted (back-to-back operation); otherwise → IDLE.
- IDLE: alpctl_h = NOP, loop_flag_h = 0.
- busy_h = 1 in DBL, LOOP and REM only.
- Invariant: FAST codes only ever appear together with loop_flag_h = 1.
- Ignored events (no state change, no error indication):
  - start while busy
  - start with op = 11
- abort_h in any state:
  - Next cycle: IDLE, NOP, loop_flag_h = 0, busy_h = 0.
  - No done_h pulse.
  - abort_h and start_h together: abort wins and the start is dropped.
- Reset, including mid-operation: state = IDLE, alpctl_h = 0x000, loop_flag_h = 0, busy_h = 0, done_h = 0, count cleared.

## Timing
- All outputs are registered.
- The code visible in cycle k+1 is computed from sel_n_h and the state sampled at the edge that ends cycle k.
- Start sampled at edge E0:
  - First code appears in cycle 1.
  - MUL: codes in cycles 1..N; done_h in cycle N+1.
  - DIV: loop in 1..N, REM in N+1, done_h in N+2.
  - DIVD: DBL in cycle 1, loop in 2..N+1, REM in N+2, done_h in N+3.
- Boundary N = 0: MUL gives done_h in cycle 1; DIV gives REM in 1 and done in 2; DIVD gives DBL in 1, REM in 2, done in 3.
- N = 2^CNT_W − 1 has no wrap-around: the count stops at r = 1.
- A start accepted in the DONE cycle places its first code in the following cycle, with no NOP gap after done.

## Test plan
- MUL, N = 3, fast_en = 1, sel = 0,1,0 at E0..E2 → alpctl 0x269, 0x279, 0x26B; loop_flag 1,1,0; busy in cycles 1–3; done_h in cycle 4 only.
- DIV, N = 2, fast_en = 0, sel = 1,0 → 0x27E, 0x26E, 0x26A; loop_flag 1,0,0; done_h in cycle 4.
- DIVD, N = 1, sel = 1 at E0 and 0 at E1 → 0x27F, 0x26E, 0x26A; done_h in cycle 4.
- N = 0 for each op → the exact cycle counts listed under Timing. op = 11 → no busy, no done.
- MUL N = 5 with abort_h at cycle 2 → NOP and idle from cycle 3, no done_h. Start during busy is ignored. Start in the DONE cycle → new first code in the next cycle.
- reset_l low mid-DIV → all outputs 0 immediately, without waiting for a clock. After release → idle until the next start.
